// File: rtl/odometer_seq_ctrl_pkg.sv
// Shared types and defaults for the odometer slice sequencer.
package odometer_pkg;

  localparam int unsigned PHASE_W    = 3;
  localparam int unsigned CNT_W_DEF  = 24;
  localparam int unsigned ITER_W_DEF = 8;

  // Encodings are visible on PHASE and must stay fixed for scan readout.
  typedef enum logic [PHASE_W-1:0] {
    S_IDLE   = 3'd0,
    S_STRESS = 3'd1,
    S_SETTLE = 3'd2,
    S_MEAS   = 3'd3,
    S_HOLD   = 3'd4
  } state_t;

endpackage

// File: rtl/odometer_seq_ctrl_if.sv
// Config/control and status bundle between scan registers (master) and the sequencer (slave).
interface odometer_seq_ctrl_if
  import odometer_pkg::*;
#(
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned ITER_W = ITER_W_DEF
);
  logic              REQ;
  logic              ABORT;
  logic [CNT_W-1:0]  CFG_STRESS_CYC;
  logic [CNT_W-1:0]  CFG_MEAS_CYC;
  logic [ITER_W-1:0] CFG_N_ITER;
  logic              START;
  logic              MEAS_STRESS;
  logic              MEAS_DONE;
  logic              BUSY;
  logic              DONE;
  logic              ABORTED;
  logic [ITER_W-1:0] ITER_CNT;
  logic [PHASE_W-1:0] PHASE;

  modport master (
    output REQ, ABORT, CFG_STRESS_CYC, CFG_MEAS_CYC, CFG_N_ITER,
    input  START, MEAS_STRESS, MEAS_DONE, BUSY, DONE, ABORTED, ITER_CNT, PHASE
  );

  modport slave (
    input  REQ, ABORT, CFG_STRESS_CYC, CFG_MEAS_CYC, CFG_N_ITER,
    output START, MEAS_STRESS, MEAS_DONE, BUSY, DONE, ABORTED, ITER_CNT, PHASE
  );
endinterface

// File: rtl/odometer_seq_ctrl_dn_counter.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a phase.
module odo_dn_counter
  import odometer_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                   cnt <= '0;
    else if (load)             cnt <= load_val;
    else if (en && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/odometer_seq_ctrl.sv
// Odometer slice sequencer: N x (stress -> settle -> measure -> hold) with abort.
module odometer_seq_ctrl
  import odometer_pkg::*;
#(
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned ITER_W     = ITER_W_DEF,
  parameter int unsigned SETTLE_CYC = 16,
  parameter int unsigned HOLD_CYC   = 8
) (
  input logic                CLK,
  input logic                RESET,
  input logic                VDD,
  input logic                VSS,
  odometer_seq_ctrl_if.slave bus
);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t            state, next_state;
  logic [CNT_W-1:0]  stress_cyc, meas_cyc, cfg_stress_nz, cfg_meas_nz, stress_src, load_val;
  logic [ITER_W-1:0] n_iter, cfg_iter_nz, iter_cnt;
  logic              zero, start_req, hold_end, last_iter, aborting;
  logic              start_d, ms_d, md_d, busy_d, done_d, aborted_d;
  logic              start_q, ms_q, md_q, busy_q, done_q, aborted_q;
  logic              unused_supply;

  assign unused_supply = VDD ^ VSS;

  assign cfg_stress_nz = (bus.CFG_STRESS_CYC == '0) ? CNT_W'(1)  : bus.CFG_STRESS_CYC;
  assign cfg_meas_nz   = (bus.CFG_MEAS_CYC   == '0) ? CNT_W'(1)  : bus.CFG_MEAS_CYC;
  assign cfg_iter_nz   = (bus.CFG_N_ITER     == '0) ? ITER_W'(1) : bus.CFG_N_ITER;

  assign aborting  = (state != S_IDLE) && bus.ABORT;
  assign start_req = (state == S_IDLE) && bus.REQ && !bus.ABORT;
  assign hold_end  = (state == S_HOLD) && zero && !bus.ABORT;
  assign last_iter = ((ITER_W+1)'(iter_cnt) + (ITER_W+1)'(1)) >= (ITER_W+1)'(n_iter);

  // Shadows are not yet valid on the IDLE->STRESS edge, so that load uses the live config.
  assign stress_src = (state == S_IDLE) ? cfg_stress_nz : stress_cyc;

  always_comb begin
    load_val = '0;
    case (next_state)
      S_STRESS: load_val = stress_src - CNT_W'(1);
      S_SETTLE: load_val = SETTLE_LD;
      S_MEAS:   load_val = meas_cyc - CNT_W'(1);
      S_HOLD:   load_val = HOLD_LD;
      default:  load_val = '0;
    endcase
  end

  odo_dn_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (CLK),
    .rst      (RESET),
    .load     (next_state != state),
    .en       (state != S_IDLE),
    .load_val (load_val),
    .zero     (zero)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      ms_q      <= 1'b0;
      md_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state     <= next_state;
      start_q   <= start_d;
      ms_q      <= ms_d;
      md_q      <= md_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stress_cyc <= '0;
      meas_cyc   <= '0;
      n_iter     <= '0;
      iter_cnt   <= '0;
    end else if (start_req) begin
      stress_cyc <= cfg_stress_nz;
      meas_cyc   <= cfg_meas_nz;
      n_iter     <= cfg_iter_nz;
      iter_cnt   <= '0;
    end else if (hold_end && iter_cnt != '1) begin
      iter_cnt   <= iter_cnt + 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    if (aborting) begin
      next_state = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start_req) next_state = S_STRESS;
        S_STRESS: if (zero) next_state = S_SETTLE;
        S_SETTLE: if (zero) next_state = S_MEAS;
        S_MEAS:   if (zero) next_state = S_HOLD;
        S_HOLD:   if (zero) next_state = last_iter ? S_IDLE : S_STRESS;
        default:  next_state = S_IDLE;
      endcase
    end
  end

  // Decoded from next_state so the registered outputs line up with the state they describe.
  always_comb begin
    start_d   = 1'b0;
    ms_d      = 1'b0;
    md_d      = 1'b0;
    case (next_state)
      S_STRESS: start_d = 1'b1;
      S_MEAS:   ms_d    = 1'b1;
      S_HOLD: begin
        ms_d = 1'b1;
        md_d = 1'b1;
      end
      default: ;
    endcase
    busy_d    = (next_state != S_IDLE);
    done_d    = hold_end && last_iter;
    aborted_d = aborting;
  end

  assign bus.START       = start_q;
  assign bus.MEAS_STRESS = ms_q;
  assign bus.MEAS_DONE   = md_q;
  assign bus.BUSY        = busy_q;
  assign bus.DONE        = done_q;
  assign bus.ABORTED     = aborted_q;
  assign bus.ITER_CNT    = iter_cnt;
  assign bus.PHASE       = state;
endmodule

// File: tb/tb_odometer_seq_ctrl.sv
// Bench for odometer_seq_ctrl: directed scenarios plus random runs against a schedule-queue model.
module tb_odometer_seq_ctrl;
  import odometer_pkg::*;

  localparam int unsigned CW     = 24;
  localparam int unsigned IW     = 8;
  localparam int unsigned SETTLE = 16;
  localparam int unsigned HOLD   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  odometer_seq_ctrl_if #(.CNT_W(CW), .ITER_W(IW)) bus ();

  odometer_seq_ctrl #(
    .CNT_W      (CW),
    .ITER_W     (IW),
    .SETTLE_CYC (SETTLE),
    .HOLD_CYC   (HOLD)
  ) dut (
    .CLK   (clk),
    .RESET (rst),
    .VDD   (1'b1),
    .VSS   (1'b0),
    .bus   (bus)
  );

  typedef struct packed {
    logic       start, ms, md, busy, done, aborted;
    logic [2:0] phase;
    logic [7:0] iter;
  } exp_t;

  // Model: a run expands into the full per-cycle list of expected outputs.
  exp_t sched[$];
  exp_t cur = '0;
  int unsigned n_checks = 0, n_pass = 0;
  int unsigned done_seen = 0, aborted_seen = 0, start_seen = 0, ms_seen = 0, md_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
  endtask

  function automatic exp_t rec(input logic st, ms, md, bsy, dn, ab,
                               input logic [2:0] ph, input logic [7:0] it);
    exp_t r;
    r.start = st; r.ms = ms; r.md = md; r.busy = bsy; r.done = dn; r.aborted = ab;
    r.phase = ph; r.iter = it;
    return r;
  endfunction

  function automatic void build_run(input logic [CW-1:0] cs, cm, input logic [IW-1:0] cn);
    int unsigned s = (cs == '0) ? 1 : int'(cs);
    int unsigned m = (cm == '0) ? 1 : int'(cm);
    int unsigned n = (cn == '0) ? 1 : int'(cn);
    for (int unsigned i = 0; i < n; i++) begin
      repeat (s)      sched.push_back(rec(1, 0, 0, 1, 0, 0, 3'd1, 8'(i)));
      repeat (SETTLE) sched.push_back(rec(0, 0, 0, 1, 0, 0, 3'd2, 8'(i)));
      repeat (m)      sched.push_back(rec(0, 1, 0, 1, 0, 0, 3'd3, 8'(i)));
      repeat (HOLD)   sched.push_back(rec(0, 1, 1, 1, 0, 0, 3'd4, 8'(i)));
    end
    sched.push_back(rec(0, 0, 0, 0, 1, 0, 3'd0, 8'(n)));
  endfunction

  task automatic model_step();
    if (rst) begin
      sched.delete();
      cur = '0;
    end else if (sched.size() != 0) begin
      if (bus.ABORT) begin
        sched.delete();
        cur = rec(0, 0, 0, 0, 0, 1, 3'd0, cur.iter);
      end else begin
        cur = sched.pop_front();
      end
    end else if (bus.REQ && !bus.ABORT) begin
      build_run(bus.CFG_STRESS_CYC, bus.CFG_MEAS_CYC, bus.CFG_N_ITER);
      cur = sched.pop_front();
    end else begin
      cur = rec(0, 0, 0, 0, 0, 0, 3'd0, cur.iter);
    end
  endtask

  task automatic compare();
    check("enables", {bus.START, bus.MEAS_STRESS, bus.MEAS_DONE}, {cur.start, cur.ms, cur.md});
    check("status",  {bus.BUSY, bus.DONE, bus.ABORTED}, {cur.busy, cur.done, cur.aborted});
    check("phase",   bus.PHASE, cur.phase);
    check("iter",    bus.ITER_CNT, cur.iter);
    if (bus.DONE === 1'b1)        done_seen++;
    if (bus.ABORTED === 1'b1)     aborted_seen++;
    if (bus.START === 1'b1)       start_seen++;
    if (bus.MEAS_STRESS === 1'b1) ms_seen++;
    if (bus.MEAS_DONE === 1'b1)   md_seen++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic clear_tally();
    done_seen = 0; aborted_seen = 0; start_seen = 0; ms_seen = 0; md_seen = 0;
  endtask

  task automatic set_cfg(input logic [CW-1:0] cs, cm, input logic [IW-1:0] cn);
    bus.CFG_STRESS_CYC = cs;
    bus.CFG_MEAS_CYC   = cm;
    bus.CFG_N_ITER     = cn;
  endtask

  task automatic start_run(input logic [CW-1:0] cs, cm, input logic [IW-1:0] cn);
    set_cfg(cs, cm, cn);
    bus.REQ = 1'b1;
    tick();
    bus.REQ = 1'b0;
  endtask

  task automatic run_until_idle(input int unsigned budget);
    int unsigned k = 0;
    while (sched.size() != 0 && k < budget) begin
      tick();
      k++;
    end
    check("run_bound", sched.size(), 0);
  endtask

  assert property (@(posedge clk) disable iff (rst) !(bus.START && bus.MEAS_STRESS))
    else $error("FAIL assert start_and_meas_overlap");
  assert property (@(posedge clk) disable iff (rst) bus.MEAS_DONE |-> bus.MEAS_STRESS)
    else $error("FAIL assert meas_done_without_meas_stress");
  assert property (@(posedge clk) disable iff (rst) bus.DONE |=> !bus.DONE)
    else $error("FAIL assert done_not_single_cycle");
  assert property (@(posedge clk) disable iff (rst) bus.ABORTED |=> !bus.ABORTED)
    else $error("FAIL assert aborted_not_single_cycle");
  assert property (@(posedge clk) disable iff (rst) !(bus.DONE && bus.ABORTED))
    else $error("FAIL assert done_and_aborted");

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k;
    bus.REQ = 1'b0;
    bus.ABORT = 1'b0;
    set_cfg('0, '0, '0);
    rst = 1'b1;
    tick();
    tick();
    check("reset_outputs", {bus.START, bus.MEAS_STRESS, bus.MEAS_DONE, bus.BUSY, bus.DONE, bus.ABORTED}, 0);
    rst = 1'b0;
    tick();

    // Basic single-iteration run.
    clear_tally();
    start_run(24'd5, 24'd3, 8'd1);
    run_until_idle(500);
    check("t1_start_cycles", start_seen, 5);
    check("t1_meas_stress_cycles", ms_seen, 3 + HOLD);
    check("t1_meas_done_cycles", md_seen, HOLD);
    check("t1_done_pulses", done_seen, 1);
    check("t1_iter_cnt", bus.ITER_CNT, 1);
    tick();

    // Three iterations back to back.
    clear_tally();
    start_run(24'd2, 24'd2, 8'd3);
    run_until_idle(500);
    check("t2_done_pulses", done_seen, 1);
    check("t2_iter_cnt", bus.ITER_CNT, 3);
    check("t2_start_cycles", start_seen, 6);

    // Zero config with REQ held: 1/1/1 run, then immediate restart.
    set_cfg('0, '0, '0);
    bus.REQ = 1'b1;
    clear_tally();
    k = 0;
    while (done_seen == 0 && k < 200) begin tick(); k++; end
    check("t3_done_seen", done_seen, 1);
    check("t3_start_cycles", start_seen, 1);
    check("t3_meas_stress_cycles", ms_seen, 1 + HOLD);
    tick();
    check("t3_restart_busy", bus.BUSY, 1);
    bus.REQ = 1'b0;
    run_until_idle(200);

    // Abort in the 2nd MEAS cycle of iteration 2 of 3.
    start_run(24'd2, 24'd4, 8'd3);
    k = 0;
    while (!(cur.phase == 3'd3 && cur.iter == 8'd1) && k < 500) begin tick(); k++; end
    check("t4_reach_meas", {cur.phase, cur.iter}, {3'd3, 8'd1});
    tick();
    bus.ABORT = 1'b1;
    clear_tally();
    tick();
    bus.ABORT = 1'b0;
    check("t4_aborted", aborted_seen, 1);
    check("t4_enables_off", {bus.START, bus.MEAS_STRESS, bus.MEAS_DONE, bus.BUSY}, 0);
    check("t4_iter_cnt", bus.ITER_CNT, 1);
    repeat (4) tick();
    check("t4_no_done", done_seen, 0);

    // Config change and REQ mid-run are ignored.
    clear_tally();
    start_run(24'd4, 24'd2, 8'd2);
    repeat (3) tick();
    set_cfg(24'd9, 24'd9, 8'd9);
    bus.REQ = 1'b1;
    tick();
    bus.REQ = 1'b0;
    run_until_idle(500);
    check("t5_start_cycles", start_seen, 8);
    check("t5_iter_cnt", bus.ITER_CNT, 2);

    // Reset during STRESS.
    start_run(24'd10, 24'd1, 8'd1);
    repeat (2) tick();
    rst = 1'b1;
    clear_tally();
    tick();
    rst = 1'b0;
    check("t6_after_reset", {bus.START, bus.BUSY, bus.PHASE}, 0);
    repeat (3) tick();
    check("t6_no_pulses", done_seen + aborted_seen, 0);

    // ABORT alone and ABORT with REQ in IDLE.
    bus.ABORT = 1'b1;
    tick();
    bus.REQ = 1'b1;
    tick();
    bus.REQ = 1'b0;
    bus.ABORT = 1'b0;
    check("t7_idle_abort", {bus.BUSY, bus.ABORTED}, 0);
    tick();

    // Largest iteration count.
    start_run(24'd1, 24'd1, 8'd255);
    run_until_idle(8000);
    check("t8_iter_max", bus.ITER_CNT, 255);

    // Random activity.
    for (int r = 0; r < 40; r++) begin
      set_cfg(24'($urandom_range(0, 6)), 24'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
      bus.REQ = 1'b1;
      tick();
      for (int c = 0; c < 150; c++) begin
        bus.ABORT = ($urandom_range(0, 63) == 0);
        bus.REQ   = ($urandom_range(0, 3) == 0);
        rst       = ($urandom_range(0, 299) == 0);
        if ($urandom_range(0, 7) == 0)
          set_cfg(24'($urandom_range(0, 6)), 24'($urandom_range(0, 4)), 8'($urandom_range(0, 3)));
        tick();
      end
      bus.ABORT = 1'b0;
      bus.REQ   = 1'b0;
      rst       = 1'b0;
      run_until_idle(500);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
